piso_bit_serializer: RTL and testbench

// - Upstream feeder for the serial sequence-detector FSM. Accepts parallel words over a

---
 rtl/serial_pkg.sv | 15 +
 rtl/bit_tick_gen.sv | 38 +++
 rtl/piso_bit_serializer.sv | 128 ++++++++++++
 tb/tb_piso_bit_serializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial feeder path.
package serial_pkg;

    // Serializer control states: waiting for a word, or shifting one out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a counter that must reach x-1; never narrower than one bit.
    function automatic int CNT_W(input int x);
        return (x < 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts clock cycles within one serial bit and flags the
// final cycle of each bit period with tick.
module bit_tick_gen
    import serial_pkg::*;
#(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int DW = CNT_W(BIT_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

    logic [DW-1:0] div_cnt;

    // With BIT_DIV=1 DIV_LAST is zero, so div_cnt stays at 0 and every enabled cycle ticks.
    assign tick = enable && (div_cnt == DIV_LAST);

    // Cycle counter within the current bit: cleared on word load, wraps on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out feeder for the sequence detector. Words arrive over a
// valid/ready handshake and leave one bit at a time on a registered dout.
//
// Handshake: a word is accepted at a rising edge where s_valid and s_ready are
// both high; s_data is sampled only then. s_ready depends on state and counters
// only (never on s_valid), is high in IDLE and in the end-of-word cycle, so a
// word accepted in the end-of-word cycle follows the previous one with no gap.
module piso_bit_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter int   BIT_DIV   = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             last_bit
);

    localparam int BW = CNT_W(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_inc;
    logic             tick;
    logic             eow;
    logic             accept;

    // Bit that goes on the wire first for a given word in the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    bit_tick_gen #(
        .BIT_DIV(BIT_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .enable(state == SHIFT),
        .tick  (tick)
    );

    // Logical shift toward the output end; the vacated position takes IDLE_BIT.
    always_comb begin
        sreg_shifted = sreg;
        if (MSB_FIRST != 0) begin
            sreg_shifted = {sreg[WIDTH-2:0], IDLE_BIT};
        end else begin
            sreg_shifted = {IDLE_BIT, sreg[WIDTH-1:1]};
        end
        bit_cnt_inc = bit_cnt + BW'(1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: stay in SHIFT across a back-to-back accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (eow && !accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs: end-of-word detection, ready and accept.
    always_comb begin
        eow     = (state == SHIFT) && (bit_cnt == BIT_LAST) && tick;
        s_ready = !rst && ((state == IDLE) || eow);
        accept  = s_valid && s_ready;
    end

    // Shift register, bit counter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            last_bit   <= 1'b0;
        end else if (accept) begin
            sreg       <= s_data;
            bit_cnt    <= '0;
            dout       <= head_bit(s_data);
            dout_valid <= 1'b1;
            last_bit   <= 1'b0;
        end else if (eow) begin
            sreg       <= sreg_shifted;
            bit_cnt    <= '0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            last_bit   <= 1'b0;
        end else if (tick) begin
            sreg       <= sreg_shifted;
            bit_cnt    <= bit_cnt_inc;
            dout       <= head_bit(sreg_shifted);
            dout_valid <= 1'b1;
            last_bit   <= (bit_cnt_inc == BIT_LAST);
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three instances (MSB-first, LSB-first, BIT_DIV=3)
// checked cycle by cycle against a word/position model, plus a word-level scoreboard.
module tb_piso_bit_serializer;

    localparam int N = 3;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0][W-1:0] s_data;
    logic [N-1:0] s_valid;
    logic [N-1:0] s_ready;
    logic [N-1:0] dout;
    logic [N-1:0] dout_valid;
    logic [N-1:0] last_bit;

    typedef struct {
        int           gap;
        logic [W-1:0] word;
    } item_t;

    item_t        wq[N][$];
    logic [W-1:0] exp_q[N][$];
    logic [W-1:0] asm_w[N];
    int           wait_cnt[N];
    bit           m_busy[N];
    logic [W-1:0] m_word[N];
    int           m_pos[N];
    bit           jitter;
    int           n_checks = 0;
    int           n_fail = 0;

    // Clock
    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            piso_bit_serializer #(
                .WIDTH    (W),
                .MSB_FIRST((g == 1) ? 0 : 1),
                .BIT_DIV  ((g == 2) ? 3 : 1),
                .IDLE_BIT (1'b0)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .s_data    (s_data[g]),
                .s_valid   (s_valid[g]),
                .s_ready   (s_ready[g]),
                .dout      (dout[g]),
                .dout_valid(dout_valid[g]),
                .last_bit  (last_bit[g])
            );
        end
    endgenerate

    function automatic int div_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int i);
        return (i != 1);
    endfunction

    // Word occupies W*div cycles; ready when idle or in its very last cycle.
    function automatic bit model_ready(input int i);
        return !rst && (!m_busy[i] || (m_pos[i] == W * div_of(i) - 1));
    endfunction

    function automatic logic model_bit(input int i);
        int idx;
        idx = m_pos[i] / div_of(i);
        return msb_of(i) ? m_word[i][W-1-idx] : m_word[i][idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One cycle, called just after a falling edge: advance the model for the rising
    // edge that has passed, compare outputs, then drive inputs for the next edge.
    task automatic step();
        for (int i = 0; i < N; i++) begin
            int  idx;
            int  last_pos;
            bit  e_dout;
            last_pos = W * div_of(i) - 1;
            if (rst) begin
                m_busy[i] = 1'b0;
                m_pos[i]  = 0;
                exp_q[i].delete();
            end else if (s_valid[i] && model_ready(i)) begin
                m_busy[i] = 1'b1;
                m_word[i] = s_data[i];
                m_pos[i]  = 0;
                exp_q[i].push_back(s_data[i]);
                s_valid[i] = 1'b0;
            end else if (m_busy[i]) begin
                if (m_pos[i] == last_pos) m_busy[i] = 1'b0;
                else m_pos[i]++;
            end

            e_dout = m_busy[i] ? model_bit(i) : 1'b0;
            idx = m_pos[i] / div_of(i);
            check($sformatf("dout_valid[%0d]", i), 32'(dout_valid[i]), 32'(m_busy[i]));
            check($sformatf("dout[%0d]", i), 32'(dout[i]), 32'(e_dout));
            check($sformatf("last_bit[%0d]", i), 32'(last_bit[i]), 32'(m_busy[i] && idx == W - 1));
            check($sformatf("s_ready[%0d]", i), 32'(s_ready[i]), 32'(model_ready(i)));

            if (m_busy[i] && (m_pos[i] % div_of(i) == 0)) begin
                asm_w[i][msb_of(i) ? W-1-idx : idx] = dout[i];
            end
            if (m_busy[i] && m_pos[i] == last_pos) begin
                if (exp_q[i].size() > 0) begin
                    check($sformatf("word[%0d]", i), 32'(asm_w[i]), 32'(exp_q[i].pop_front()));
                end else begin
                    check($sformatf("sb_empty[%0d]", i), 32'(exp_q[i].size()), 32'd1);
                end
            end

            if (!s_valid[i] && wq[i].size() > 0) begin
                if (wait_cnt[i] >= wq[i][0].gap) begin
                    item_t it;
                    it = wq[i].pop_front();
                    s_data[i]   = it.word;
                    s_valid[i]  = 1'b1;
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                end
            end else if (s_valid[i] && jitter) begin
                s_data[i] = W'($urandom);
            end
        end
    endtask

    task automatic push_all(input int gap, input logic [W-1:0] word);
        item_t it;
        it.gap  = gap;
        it.word = word;
        for (int i = 0; i < N; i++) wq[i].push_back(it);
    endtask

    task automatic run_until_idle(input int budget);
        bit done;
        int cyc;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            step();
            cyc++;
            done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (wq[i].size() > 0 || s_valid[i] || m_busy[i]) done = 1'b0;
            end
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        bit reached;
        s_valid = '0;
        s_data  = '0;
        jitter  = 1'b0;
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = 0;
            m_busy[i]   = 1'b0;
            m_pos[i]    = 0;
            m_word[i]   = '0;
            asm_w[i]    = '0;
        end

        // Reset state
        repeat (2) begin
            @(negedge clk);
            step();
        end
        rst = 1'b0;

        // Directed words: isolated, back-to-back, single-bit and all-ones
        push_all(3, 8'hC0);
        push_all(2, 8'hA5);
        push_all(0, 8'h3C);
        push_all(2, 8'h01);
        push_all(1, 8'h80);
        push_all(0, 8'hFF);
        run_until_idle(600);

        // Random words with random gaps, including zero-gap runs
        for (int k = 0; k < 30; k++) begin
            push_all($urandom_range(0, 3), W'($urandom));
        end
        run_until_idle(3000);

        // s_data changing while s_valid waits on a busy serializer
        jitter = 1'b1;
        for (int k = 0; k < 8; k++) push_all(0, W'($urandom));
        run_until_idle(1000);
        jitter = 1'b0;

        // Mid-word asynchronous reset after three bits of 8'hFF
        push_all(0, 8'hFF);
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge clk);
            step();
            if (m_busy[0] && m_pos[0] == 3) reached = 1'b1;
        end
        check("reach_bit3", 32'(reached), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_dout[%0d]", i), 32'(dout[i]), 32'd0);
            check($sformatf("rst_dout_valid[%0d]", i), 32'(dout_valid[i]), 32'd0);
            check($sformatf("rst_s_ready[%0d]", i), 32'(s_ready[i]), 32'd0);
            check($sformatf("rst_last_bit[%0d]", i), 32'(last_bit[i]), 32'd0);
        end
        @(negedge clk);
        step();
        rst = 1'b0;
        push_all(0, 8'h0F);
        run_until_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
